// File: rtl/iir_dec_buf.sv
// Decimating integrate-and-dump stage behind the IIR filter: averages R samples with
// round-half-up, then queues results in a show-ahead FIFO with a valid/ready output.
module iir_dec_buf #(
    parameter int W     = 14,
    parameter int R     = 4,
    parameter int LOGR  = 2,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic signed [W:0]   x_in,
    output logic signed [W:0]   y_out,
    output logic                y_valid,
    input  logic                y_ready,
    output logic                full,
    output logic [AW:0]         count,
    output logic                overflow
);

    localparam int ACCW = W + 1 + LOGR;
    localparam logic [LOGR-1:0] PHASE_LAST = LOGR'(R - 1);
    localparam logic signed [ACCW:0] HALF = (ACCW + 1)'(1) <<< (LOGR - 1);
    localparam logic [AW:0] COUNT_FULL = (AW + 1)'(DEPTH);

    logic [LOGR-1:0]         phase;
    logic signed [ACCW-1:0]  acc;
    logic signed [ACCW-1:0]  x_ext;
    logic signed [ACCW-1:0]  sum;
    logic signed [ACCW:0]    rnd_sum;
    logic signed [W:0]       res_next;
    logic signed [W:0]       res;
    logic                    res_v;

    logic signed [W:0]       mem [DEPTH];
    logic [AW-1:0]           wr_ptr;
    logic [AW-1:0]           rd_ptr;
    logic [AW:0]             cnt;
    logic                    push;
    logic                    pop;

    // One spare bit on the rounding sum so adding R/2 to the extreme group total cannot wrap.
    always_comb begin
        x_ext    = {{LOGR{x_in[W]}}, x_in};
        sum      = acc + x_ext;
        rnd_sum  = {sum[ACCW-1], sum} + HALF;
        res_next = (W + 1)'(rnd_sum >>> LOGR);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            phase <= '0;
            acc   <= '0;
            res   <= '0;
            res_v <= 1'b0;
        end else begin
            res_v <= 1'b0;
            if (en) begin
                phase <= phase + LOGR'(1);
                if (phase == '0) begin
                    acc <= x_ext;
                end else if (phase == PHASE_LAST) begin
                    res   <= res_next;
                    res_v <= 1'b1;
                end else begin
                    acc <= sum;
                end
            end
        end
    end

    always_comb begin
        y_valid = (cnt != '0);
        full    = (cnt == COUNT_FULL);
        count   = cnt;
        pop     = y_valid & y_ready;
        // A pop on the same edge frees the slot the incoming result needs.
        push    = res_v & (~full | pop);
        y_out   = y_valid ? mem[rd_ptr] : '0;
    end

    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem[wr_ptr] <= res;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                cnt <= cnt + (AW + 1)'(1);
            end else if (pop && !push) begin
                cnt <= cnt - (AW + 1)'(1);
            end
            if (res_v && !push) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_iir_dec_buf.sv
// Self-checking bench for iir_dec_buf: queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_iir_dec_buf;

    localparam int W     = 14;
    localparam int R     = 4;
    localparam int LOGR  = 2;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic                clk;
    logic                reset;
    logic                en;
    logic signed [W:0]   x_in;
    logic signed [W:0]   y_out;
    logic                y_valid;
    logic                y_ready;
    logic                full;
    logic [AW:0]         count;
    logic                overflow;

    int checks   = 0;
    int failures = 0;
    bit armed    = 0;

    iir_dec_buf #(.W(W), .R(R), .LOGR(LOGR), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .x_in     (x_in),
        .y_out    (y_out),
        .y_valid  (y_valid),
        .y_ready  (y_ready),
        .full     (full),
        .count    (count),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mean of R accepted samples, rounded half up (floor of (sum+R/2)/R).
    int m_q[$];
    int m_sum = 0;
    int m_n = 0;
    int m_pend = 0;
    bit m_pend_v = 0;
    bit m_ovf = 0;

    function automatic int round_avg(input int s);
        int t;
        int q;
        t = s + R / 2;
        q = t / R;
        if ((t % R != 0) && (t < 0)) q = q - 1;
        return q;
    endfunction

    always @(posedge clk) begin
        if (!reset) begin
            m_q.delete();
            m_sum    = 0;
            m_n      = 0;
            m_pend_v = 0;
            m_ovf    = 0;
        end else begin
            if (m_q.size() > 0 && y_ready) void'(m_q.pop_front());
            if (m_pend_v) begin
                if (m_q.size() < DEPTH) m_q.push_back(m_pend);
                else m_ovf = 1;
            end
            m_pend_v = 0;
            if (en) begin
                m_sum = m_sum + int'(x_in);
                m_n   = m_n + 1;
                if (m_n == R) begin
                    m_pend   = round_avg(m_sum);
                    m_pend_v = 1;
                    m_sum    = 0;
                    m_n      = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (armed) begin
            chk("model_y_valid", y_valid, (m_q.size() > 0) ? 1 : 0);
            chk("model_count", count, m_q.size());
            chk("model_full", full, (m_q.size() == DEPTH) ? 1 : 0);
            chk("model_y_out", y_out, (m_q.size() > 0) ? m_q[0] : 0);
            chk("model_overflow", overflow, m_ovf ? 1 : 0);
            if (y_valid) begin
                chk("y_out_range", ((int'(y_out) >= -(1 << W)) && (int'(y_out) <= (1 << W) - 1)) ? 1 : 0, 1);
            end
        end
    end

    task automatic step(input logic e, input int x, input logic r);
        en      = e;
        x_in    = x[W:0];
        y_ready = r;
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(1'b0, 0, 1'b0);
        reset = 1'b1;
    endtask

    task automatic feed4(input int a, input int b, input int c, input int d, input logic r);
        step(1'b1, a, r);
        step(1'b1, b, r);
        step(1'b1, c, r);
        step(1'b1, d, r);
    endtask

    // Feeds one group with y_ready=1 and checks the 2-cycle latency and 1-cycle output.
    task automatic group_lit(input string name, input int a, input int b, input int c, input int d,
                             input int exp);
        feed4(a, b, c, d, 1'b1);
        chk({name, "_early"}, y_valid, 0);
        step(1'b0, 0, 1'b1);
        chk({name, "_valid"}, y_valid, 1);
        chk({name, "_y_out"}, y_out, exp);
        step(1'b0, 0, 1'b1);
        chk({name, "_drop"}, y_valid, 0);
    endtask

    initial begin
        reset   = 1'b0;
        en      = 1'b0;
        x_in    = '0;
        y_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        armed = 1;
        chk("rst_count", count, 0);
        chk("rst_valid", y_valid, 0);
        chk("rst_full", full, 0);
        chk("rst_y_out", y_out, 0);
        chk("rst_overflow", overflow, 0);
        reset = 1'b1;

        group_lit("basic", 100, 200, 300, 401, 250);
        group_lit("neg", -1, -1, -1, -2, -1);
        group_lit("max", 16383, 16383, 16383, 16383, 16383);
        group_lit("min", -16384, -16384, -16384, -16384, -16384);

        step(1'b1, 100, 1'b1);
        step(1'b0, 999, 1'b1);
        step(1'b1, 200, 1'b1);
        step(1'b0, 7, 1'b1);
        step(1'b0, 7, 1'b1);
        step(1'b1, 300, 1'b1);
        step(1'b0, 5, 1'b1);
        chk("gap_early", y_valid, 0);
        step(1'b1, 401, 1'b1);
        step(1'b0, 0, 1'b1);
        chk("gap_valid", y_valid, 1);
        chk("gap_y_out", y_out, 250);
        step(1'b0, 0, 1'b1);

        for (int g = 1; g <= 5; g++) feed4(g, g, g, g, 1'b0);
        step(1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b0);
        chk("ovf_count", count, 4);
        chk("ovf_full", full, 1);
        chk("ovf_flag", overflow, 1);
        for (int g = 1; g <= 4; g++) begin
            chk("ovf_drain_y_out", y_out, g);
            step(1'b0, 0, 1'b1);
        end
        chk("ovf_empty", y_valid, 0);
        chk("ovf_sticky", overflow, 1);

        step(1'b1, 1000, 1'b1);
        step(1'b1, 1000, 1'b1);
        reset = 1'b0;
        step(1'b0, 0, 1'b1);
        chk("midrst_count", count, 0);
        chk("midrst_overflow", overflow, 0);
        reset = 1'b1;
        group_lit("midrst", 8, 8, 8, 8, 8);

        do_reset();
        for (int g = 5; g <= 8; g++) feed4(g, g, g, g, 1'b0);
        step(1'b0, 0, 1'b0);
        step(1'b0, 0, 1'b0);
        chk("pp_full", full, 1);
        feed4(9, 9, 9, 9, 1'b0);
        step(1'b0, 0, 1'b1);
        chk("pp_count", count, 4);
        chk("pp_overflow", overflow, 0);
        for (int g = 6; g <= 9; g++) begin
            chk("pp_y_out", y_out, g);
            step(1'b0, 0, 1'b1);
        end
        chk("pp_empty", y_valid, 0);

        for (int i = 0; i < 4000; i++) begin
            int rdy_pct;
            rdy_pct = (i < 2000) ? 30 : 90;
            reset = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
            step(($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
                 int'($urandom_range(0, 32767)) - 16384,
                 ($urandom_range(0, 99) < rdy_pct) ? 1'b1 : 1'b0);
        end
        reset = 1'b1;
        step(1'b0, 0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
